mem_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the fetch requester (IF, id 0) and the load/store requester (EXE, id 1).

---
 rtl/mem_port_arbiter_pkg.sv | 47 ++++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter_id_fifo.sv | 79 +++++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | Module   : mem_port_arbiter_pkg                                     |
// | Purpose  : Shared constants, types and helpers for the memory port  |
// |            arbiter (requester ids, transfer sizes, FSM encoding).   |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  // Requester ids carried through the outstanding-transaction FIFO
  localparam logic C_MEM_ID_IF   = 1'b0;
  localparam logic C_MEM_ID_DATA = 1'b1;

  // Transfer size encodings on the SRAM-like bus
  localparam logic [1:0] C_MEM_SIZE_B = 2'd0;
  localparam logic [1:0] C_MEM_SIZE_H = 2'd1;
  localparam logic [1:0] C_MEM_SIZE_W = 2'd2;

  // Default number of accepted-but-unreturned transactions
  localparam int C_MEM_ARB_MAX_OUTST = 2;

  // Arbiter FSM encoding
  localparam logic [0:0] C_ST_ARB  = 1'b0;
  localparam logic [0:0] C_ST_LOCK = 1'b1;

  // Control fields of an address phase that differ between requesters
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [3:0] wstrb;
  } mem_ctrl_t;

  // Pick a requester when free to choose; 'fav' breaks a tie
  function automatic logic arb_pick(input logic if_req, input logic exe_req, input logic fav);
    if (if_req && exe_req) begin
      return fav;
    end else if (exe_req) begin
      return C_MEM_ID_DATA;
    end else begin
      return C_MEM_ID_IF;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +--------------------------------------------------------------------+
// | Module   : mem_port_arbiter_if                                      |
// | Purpose  : SRAM-like request/response bus. The master drives the    |
// |            address phase, the slave returns addr_ok/data_ok/rdata.  |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  // Side that issues address phases
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts address phases and returns data
  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_id_fifo.sv
// +--------------------------------------------------------------------+
// | Module   : mem_id_fifo                                              |
// | Purpose  : DEPTH x 1-bit FIFO of requester ids for in-order         |
// |            outstanding transactions. Pop on empty is ignored.       |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_id_fifo #(
  parameter int DEPTH = 2
)(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic                       i_push_id,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == C_PTR_LAST) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Qualify push/pop: a pop frees room for a same-cycle push
  always_comb begin
    w_do_pop  = i_pop && (r_cnt != '0);
    w_do_push = i_push && ((r_cnt != C_CNT_FULL) || w_do_pop);
  end

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == C_CNT_FULL);
  assign o_empty = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                         |
// | Purpose  : Shares one SRAM-like memory port between the fetch (IF,  |
// |            id 0) and load/store (EXE, id 1) requesters. One address |
// |            phase at a time, in-order return routing by id FIFO.     |
// |            inst_bus = i_* signals, data_bus = d_*, mem_bus = m_*.   |
// | Config   : MEM_ARB_RR_EN defined -> round-robin tie break,          |
// |            otherwise fixed priority EXE over IF.                    |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = C_MEM_ARB_MAX_OUTST,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
)(
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.slave  inst_bus,
  mem_port_arbiter_if.slave  data_bus,
  mem_port_arbiter_if.master mem_bus
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_lock_id;
  logic              w_fav;
  logic              w_grant;
  logic              w_m_req;
  logic              w_push;
  logic              w_pop;
  logic              w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_cnt;
  mem_ctrl_t         w_ctrl;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  logic              w_i_addr_ok;
  logic              w_d_addr_ok;
  logic              w_i_data_ok;
  logic              w_d_data_ok;

`ifdef MEM_ARB_RR_EN
  logic r_rr;

  // Favour the side that was not served by the last accepted address phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr <= C_MEM_ID_IF;
    end else if (w_push) begin
      r_rr <= ~w_grant;
    end
  end

  assign w_fav = r_rr;
`else
  assign w_fav = C_MEM_ID_DATA;
`endif

  // State register; the grant is frozen when a handshake stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= C_ST_ARB;
      r_lock_id <= C_MEM_ID_IF;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == C_ST_ARB) && (w_state_nxt == C_ST_LOCK)) begin
        r_lock_id <= w_grant;
      end
    end
  end

  // Next state: lock on a stalled request, release once it is accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_ARB: begin
        if (w_m_req && !mem_bus.addr_ok) begin
          w_state_nxt = C_ST_LOCK;
        end
      end
      C_ST_LOCK: begin
        if (w_m_req && mem_bus.addr_ok) begin
          w_state_nxt = C_ST_ARB;
        end
      end
      default: w_state_nxt = C_ST_ARB;
    endcase
  end

  // Outputs: grant, payload mux, address handshake and return routing
  always_comb begin
    w_grant = (r_state == C_ST_LOCK) ? r_lock_id
                                     : arb_pick(inst_bus.req, data_bus.req, w_fav);
    // Registered count only: a return this cycle does not free a slot yet
    w_m_req = (inst_bus.req || data_bus.req) && (w_cnt < CNT_W'(MAX_OUTST));

    if (w_grant == C_MEM_ID_DATA) begin
      w_ctrl.wr    = data_bus.wr;
      w_ctrl.size  = data_bus.size;
      w_ctrl.wstrb = data_bus.wstrb;
      w_m_addr     = data_bus.addr;
      w_m_wdata    = data_bus.wdata;
    end else begin
      w_ctrl.wr    = 1'b0;
      w_ctrl.size  = C_MEM_SIZE_W;
      w_ctrl.wstrb = 4'h0;
      w_m_addr     = inst_bus.addr;
      w_m_wdata    = '0;
    end

    w_push      = w_m_req && mem_bus.addr_ok;
    w_i_addr_ok = w_push && (w_grant == C_MEM_ID_IF);
    w_d_addr_ok = w_push && (w_grant == C_MEM_ID_DATA);

    // A return with nothing outstanding is dropped silently
    w_pop       = mem_bus.data_ok && !w_empty;
    w_i_data_ok = w_pop && (w_head == C_MEM_ID_IF);
    w_d_data_ok = w_pop && (w_head == C_MEM_ID_DATA);
  end

  mem_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_push_id (w_grant),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_cnt     (w_cnt),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign mem_bus.req      = w_m_req;
  assign mem_bus.wr       = w_ctrl.wr;
  assign mem_bus.size     = w_ctrl.size;
  assign mem_bus.wstrb    = w_ctrl.wstrb;
  assign mem_bus.addr     = w_m_addr;
  assign mem_bus.wdata    = w_m_wdata;

  assign inst_bus.addr_ok = w_i_addr_ok;
  assign inst_bus.data_ok = w_i_data_ok;
  assign inst_bus.rdata   = mem_bus.rdata;

  assign data_bus.addr_ok = w_d_addr_ok;
  assign data_bus.data_ok = w_d_data_ok;
  assign data_bus.rdata   = mem_bus.rdata;

  // The fetch side never writes; its write fields are ignored
  logic w_unused;
  assign w_unused = &{1'b0, inst_bus.wr, inst_bus.size, inst_bus.wstrb,
                      inst_bus.wdata, w_full};

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                      |
// | Purpose  : Self-checking bench: directed scenarios plus random      |
// |            traffic against a transaction-level reference model.     |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_OUTST = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_port_arbiter #(.MAX_OUTST(MAX_OUTST), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_bus),
    .data_bus (data_bus),
    .mem_bus  (mem_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding ids in issue order, held grant, favoured side
  int          q_ids[$];
  bit          lock_valid;
  bit          lock_id;
  bit          fav;
  logic [31:0] slave_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  // Last observed DUT values, for the directed scenarios
  logic        obs_m_req, obs_m_wr, obs_i_aok, obs_d_aok, obs_i_dok, obs_d_dok;
  logic [1:0]  obs_m_size;
  logic [31:0] obs_m_addr, obs_i_rdata;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC2AD_BEEF;
  endfunction

  task automatic model_clear();
    q_ids.delete();
    slave_q.delete();
    if_exp_q.delete();
    d_exp_q.delete();
    lock_valid = 1'b0;
    lock_id    = 1'b0;
    fav        = 1'b0;
  endtask

  // One bus cycle: apply slave response, compare against the model, advance
  task automatic cycle(input bit aok, input bit dok);
    bit          exp_req, g, ia, da, idk, ddk, popv;
    logic [31:0] ea;
    mem_bus.addr_ok = aok;
    mem_bus.data_ok = dok;
    mem_bus.rdata   = (slave_q.size() > 0) ? mem_val(slave_q[0]) : $urandom;
    #2;
    obs_m_req   = mem_bus.req;
    obs_m_wr    = mem_bus.wr;
    obs_m_size  = mem_bus.size;
    obs_m_addr  = mem_bus.addr;
    obs_i_aok   = inst_bus.addr_ok;
    obs_d_aok   = data_bus.addr_ok;
    obs_i_dok   = inst_bus.data_ok;
    obs_d_dok   = data_bus.data_ok;
    obs_i_rdata = inst_bus.rdata;

    exp_req = (inst_bus.req || data_bus.req) && (q_ids.size() < MAX_OUTST);
    if (lock_valid)                        g = lock_id;
    else if (inst_bus.req && data_bus.req) g = RR_EN ? fav : 1'b1;
    else                                   g = data_bus.req;
    ea = g ? data_bus.addr : inst_bus.addr;

    check_val("m_req", mem_bus.req, exp_req);
    if (exp_req) begin
      check_val("m_addr", mem_bus.addr, ea);
      check_val("m_wr", mem_bus.wr, g ? data_bus.wr : 1'b0);
      check_val("m_size", mem_bus.size, g ? data_bus.size : C_MEM_SIZE_W);
      check_val("m_wstrb", mem_bus.wstrb, g ? data_bus.wstrb : 4'h0);
      if (g) check_val("m_wdata", mem_bus.wdata, data_bus.wdata);
    end
    ia = exp_req && aok && !g;
    da = exp_req && aok && g;
    check_val("i_addr_ok", inst_bus.addr_ok, ia);
    check_val("d_addr_ok", data_bus.addr_ok, da);

    popv = dok && (q_ids.size() > 0);
    idk  = popv && (q_ids[0] == 0);
    ddk  = popv && (q_ids[0] == 1);
    check_val("i_data_ok", inst_bus.data_ok, idk);
    check_val("d_data_ok", data_bus.data_ok, ddk);

    // End-to-end: each requester sees its own data in its own order
    if (inst_bus.data_ok) begin
      if (if_exp_q.size() == 0) check_val("if_spurious", inst_bus.data_ok, 1'b0);
      else check_val("i_rdata", inst_bus.rdata, mem_val(if_exp_q.pop_front()));
    end
    if (data_bus.data_ok) begin
      if (d_exp_q.size() == 0) check_val("d_spurious", data_bus.data_ok, 1'b0);
      else check_val("d_rdata", data_bus.rdata, mem_val(d_exp_q.pop_front()));
    end

    if (popv) begin
      void'(q_ids.pop_front());
      void'(slave_q.pop_front());
    end
    if (exp_req && aok) begin
      q_ids.push_back(int'(g));
      slave_q.push_back(ea);
      fav        = !g;
      lock_valid = 1'b0;
    end else begin
      lock_valid = exp_req;
      lock_id    = g;
    end
    if (ia) if_exp_q.push_back(inst_bus.addr);
    if (da) d_exp_q.push_back(data_bus.addr);

    @(posedge clk);
    #1;
    if (ia) inst_bus.req = 1'b0;
    if (da) data_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
  endtask

  // Asynchronous reset in mid-cycle, with a stray return offered during it
  task automatic do_reset();
    inst_bus.req    = 1'b0;
    data_bus.req    = 1'b0;
    mem_bus.addr_ok = 1'b1;
    mem_bus.data_ok = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check_val("rst_m_req", mem_bus.req, 1'b0);
    check_val("rst_i_aok", inst_bus.addr_ok, 1'b0);
    check_val("rst_d_aok", data_bus.addr_ok, 1'b0);
    check_val("rst_i_dok", inst_bus.data_ok, 1'b0);
    check_val("rst_d_dok", data_bus.data_ok, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic set_if(input logic [31:0] a);
    inst_bus.req  = 1'b1;
    inst_bus.addr = a;
  endtask

  task automatic set_d(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] st, input logic [31:0] wd);
    data_bus.req   = 1'b1;
    data_bus.wr    = wr;
    data_bus.addr  = a;
    data_bus.size  = sz;
    data_bus.wstrb = st;
    data_bus.wdata = wd;
  endtask

  initial begin
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd0;
    inst_bus.wstrb = 4'h0; inst_bus.addr = '0; inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0;
    data_bus.wstrb = 4'h0; data_bus.addr = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // 1: IF alone, accepted at once, data two cycles later
    set_if(32'h1c00_0000);
    cycle(1, 0);
    check_val("t1_m_req", obs_m_req, 1'b1);
    check_val("t1_m_wr", obs_m_wr, 1'b0);
    check_val("t1_m_size", obs_m_size, 2'd2);
    check_val("t1_i_aok", obs_i_aok, 1'b1);
    cycle(0, 0);
    check_val("t1_one_beat", obs_m_req, 1'b0);
    cycle(0, 1);
    check_val("t1_i_dok", obs_i_dok, 1'b1);
    check_val("t1_i_rdata", obs_i_rdata, 32'hDEAD_BEEF);
    check_val("t1_d_dok", obs_d_dok, 1'b0);

    // 2: simultaneous requests; after reset round-robin favours IF
    do_reset();
    set_if(32'h1c00_0004);
    set_d(1'b1, 32'h0000_0008, C_MEM_SIZE_W, 4'hF, 32'h1234_5678);
    cycle(1, 0);
    check_val("t2_first", obs_m_addr, RR_EN ? 32'h1c00_0004 : 32'h0000_0008);
    cycle(1, 0);
    check_val("t2_second", obs_m_addr, RR_EN ? 32'h0000_0008 : 32'h1c00_0004);
    cycle(0, 1);
    check_val("t2_ret1_d", obs_d_dok, !RR_EN);
    cycle(0, 1);
    check_val("t2_ret2_i", obs_i_dok, !RR_EN);

    // 3: slave stalls three cycles on an EXE store while IF arrives
    set_d(1'b1, 32'h0000_0100, C_MEM_SIZE_H, 4'h3, 32'hA5A5_0001);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_if(32'h1c00_0010);
      cycle(0, 0);
      check_val("t3_addr", obs_m_addr, 32'h0000_0100);
      check_val("t3_wr", obs_m_wr, 1'b1);
      check_val("t3_i_aok", obs_i_aok, 1'b0);
    end
    cycle(1, 0);
    check_val("t3_d_aok", obs_d_aok, 1'b1);
    cycle(1, 0);
    check_val("t3_i_after", obs_i_aok, 1'b1);
    cycle(0, 1);
    cycle(0, 1);

    // 4: FIFO full blocks m_req until the cycle after a return
    set_if(32'h1c00_0020);
    set_d(1'b0, 32'h0000_0040, C_MEM_SIZE_W, 4'h0, 32'h0);
    cycle(1, 0);
    cycle(1, 0);
    set_if(32'h1c00_0024);
    cycle(1, 0);
    check_val("t4_full_req", obs_m_req, 1'b0);
    check_val("t4_full_iaok", obs_i_aok, 1'b0);
    cycle(1, 1);
    check_val("t4_no_passthru", obs_m_req, 1'b0);
    cycle(1, 0);
    check_val("t4_reassert", obs_m_req, 1'b1);
    check_val("t4_i_aok", obs_i_aok, 1'b1);
    cycle(0, 1);
    cycle(0, 1);

    // 5: push and pop together at one outstanding, then alternating run
    set_if(32'h1c00_0030);
    cycle(1, 0);
    set_d(1'b0, 32'h0000_0200, C_MEM_SIZE_B, 4'h0, 32'h0);
    cycle(1, 1);
    check_val("t5_i_dok", obs_i_dok, 1'b1);
    check_val("t5_d_aok", obs_d_aok, 1'b1);
    cycle(0, 1);
    check_val("t5_head_d", obs_d_dok, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) set_if(32'h1c00_1000 + 32'(k * 4));
      else set_d(1'b0, 32'h0000_3000 + 32'(k * 4), C_MEM_SIZE_W, 4'h0, 32'h0);
      cycle(1, k != 0);
      check_val("t5_alt_i", obs_i_dok, (k % 2) == 1);
      check_val("t5_alt_d", obs_d_dok, (k != 0) && (k % 2 == 0));
    end
    cycle(0, 1);
    check_val("t5_last_d", obs_d_dok, 1'b1);

    // 6: reset with two outstanding, late return must be dropped
    set_if(32'h1c00_0040);
    set_d(1'b1, 32'h0000_0400, C_MEM_SIZE_W, 4'hF, 32'h5555_AAAA);
    cycle(1, 0);
    cycle(1, 0);
    do_reset();
    cycle(0, 1);
    check_val("t6_i_dok", obs_i_dok, 1'b0);
    check_val("t6_d_dok", obs_d_dok, 1'b0);
    set_if(32'h1c00_0050);
    set_d(1'b0, 32'h0000_0500, C_MEM_SIZE_W, 4'h0, 32'h0);
    cycle(1, 0);
    check_val("t6_cnt_free1", obs_m_req, 1'b1);
    cycle(1, 0);
    check_val("t6_cnt_free2", obs_m_req, 1'b1);
    cycle(0, 1);
    cycle(0, 1);

    // Random traffic with stalls and occasional stray returns
    for (int n = 0; n < 3000; n++) begin
      bit dok;
      if (!inst_bus.req && ($urandom_range(0, 2) != 0))
        set_if($urandom & 32'hFFFF_FFFC);
      if (!data_bus.req && ($urandom_range(0, 2) != 0))
        set_d(1'($urandom), $urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom);
      dok = (slave_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      cycle($urandom_range(0, 3) != 0, dok);
    end
    inst_bus.req = 1'b0;
    data_bus.req = 1'b0;
    repeat (MAX_OUTST + 2) cycle(0, slave_q.size() > 0);
    check_val("drain_if", if_exp_q.size(), 0);
    check_val("drain_d", d_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
